// File: rtl/error_collector_if.sv
// Error-report bus: per-source report handshake plus the log-head consumer port.
// The master side is the reporters and the consumer; the slave side is error_collector.
interface error_collector_if #(
    parameter int N_SRC     = 4,
    parameter int LOG_DEPTH = 16
);
    logic [N_SRC-1:0]           src_valid;
    logic [N_SRC-1:0]           src_ready;
    logic [N_SRC*8-1:0]         src_code;
    logic [N_SRC*12-1:0]        src_txn_id;
    logic [N_SRC*48-1:0]        src_addr;

    logic                       log_valid;
    logic                       log_ready;
    logic [7:0]                 log_code;
    logic [11:0]                log_txn_id;
    logic [47:0]                log_addr;
    logic [3:0]                 log_src;
    logic [31:0]                log_timestamp;
    logic [$clog2(LOG_DEPTH):0] log_count;
    logic                       log_full;

    modport master (
        output src_valid, src_code, src_txn_id, src_addr, log_ready,
        input  src_ready, log_valid, log_code, log_txn_id, log_addr, log_src,
               log_timestamp, log_count, log_full
    );

    modport slave (
        input  src_valid, src_code, src_txn_id, src_addr, log_ready,
        output src_ready, log_valid, log_code, log_txn_id, log_addr, log_src,
               log_timestamp, log_count, log_full
    );
endinterface

// File: rtl/error_collector.sv
// Round-robin error collector: arbitrates N_SRC reporters into a circular log with statistics.
// Define ERROR_COLLECTOR_TIMESTAMP_EN to capture a free-running 32-bit cycle count per entry.
module error_collector #(
    parameter int N_SRC      = 4,
    parameter int LOG_DEPTH  = 16,
    parameter int OVERWRITE  = 0,
    parameter int CNT_W      = 16,
    parameter int IRQ_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    error_collector_if.slave  bus,
    output logic              irq,
    input  logic              irq_clear,
    output logic [CNT_W-1:0]  total_errors,
    output logic [CNT_W-1:0]  crc_errors,
    output logic [CNT_W-1:0]  timeout_errors,
    output logic [CNT_W-1:0]  protocol_errors,
    output logic [CNT_W-1:0]  overflow_errors
);

    localparam int PTR_W  = $clog2(LOG_DEPTH);
    localparam int CNT_LW = PTR_W + 1;
    localparam logic [CNT_LW-1:0] DEPTH_C  = CNT_LW'(LOG_DEPTH);
    localparam logic [CNT_LW-1:0] THRESH_C = CNT_LW'(IRQ_THRESH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        if (!en || (&c))
            return c;
        return c + CNT_W'(1);
    endfunction

    logic [3:0]        last_gnt;
    logic              gnt_vld;
    int                gsel;
    int                idx;
    logic [7:0]        gnt_code;
    logic [11:0]       gnt_txn;
    logic [47:0]       gnt_addr;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_LW-1:0] log_count_r;
    logic [CNT_LW-1:0] count_nxt;

    logic [7:0]        mem_code [LOG_DEPTH];
    logic [11:0]       mem_txn  [LOG_DEPTH];
    logic [47:0]       mem_addr [LOG_DEPTH];
    logic [3:0]        mem_src  [LOG_DEPTH];

    logic push, pop, full, ovw, drop, wr_en, rd_adv, cnt_up;

    // Search starts just after the last granted index, so index 0 leads out of reset.
    always_comb begin
        gnt_vld = 1'b0;
        gsel    = 0;
        idx     = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(last_gnt) + k) % N_SRC;
            if (!gnt_vld && ((bus.src_valid >> idx) & N_SRC'(1)) != '0) begin
                gnt_vld = 1'b1;
                gsel    = idx;
            end
        end
    end

    assign bus.src_ready = gnt_vld ? (N_SRC'(1) << gsel) : '0;
    assign gnt_code      = 8'(bus.src_code >> (8 * gsel));
    assign gnt_txn       = 12'(bus.src_txn_id >> (12 * gsel));
    assign gnt_addr      = 48'(bus.src_addr >> (48 * gsel));

    // Code 00 is a null report: granted so the reporter never stalls, otherwise ignored.
    assign push   = gnt_vld && (gnt_code != 8'h00);
    assign pop    = bus.log_valid && bus.log_ready;
    assign full   = (log_count_r == DEPTH_C);
    assign ovw    = push && full && !pop && (OVERWRITE != 0);
    assign drop   = push && full && !pop && (OVERWRITE == 0);
    assign wr_en  = push && !drop;
    assign rd_adv = pop || ovw;
    assign cnt_up = wr_en && !ovw;

    always_comb begin
        count_nxt = log_count_r;
        if (cnt_up && !pop)
            count_nxt = log_count_r + CNT_LW'(1);
        else if (!cnt_up && pop)
            count_nxt = log_count_r - CNT_LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt    <= 4'(N_SRC - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            log_count_r <= '0;
        end else begin
            if (gnt_vld)
                last_gnt <= 4'(gsel);
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_adv)
                rd_ptr <= rd_ptr + PTR_W'(1);
            log_count_r <= count_nxt;
        end
    end

    // Entry storage carries no reset; pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_code[wr_ptr] <= gnt_code;
            mem_txn[wr_ptr]  <= gnt_txn;
            mem_addr[wr_ptr] <= gnt_addr;
            mem_src[wr_ptr]  <= 4'(gsel);
        end
    end

    assign bus.log_valid  = (log_count_r != '0);
    assign bus.log_full   = full;
    assign bus.log_count  = log_count_r;
    assign bus.log_code   = mem_code[rd_ptr];
    assign bus.log_txn_id = mem_txn[rd_ptr];
    assign bus.log_addr   = mem_addr[rd_ptr];
    assign bus.log_src    = mem_src[rd_ptr];

`ifdef ERROR_COLLECTOR_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] mem_ts [LOG_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ts_cnt <= '0;
        else
            ts_cnt <= ts_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_ts[wr_ptr] <= ts_cnt;
    end

    assign bus.log_timestamp = mem_ts[rd_ptr];
`else
    assign bus.log_timestamp = 32'h0;
`endif

    // Statistics count every granted non-null report, including ones the full log drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_errors    <= '0;
            crc_errors      <= '0;
            timeout_errors  <= '0;
            protocol_errors <= '0;
            overflow_errors <= '0;
        end else begin
            total_errors    <= sat_inc(total_errors, push);
            crc_errors      <= sat_inc(crc_errors, push && (gnt_code == 8'h01));
            timeout_errors  <= sat_inc(timeout_errors, push && (gnt_code == 8'h02));
            protocol_errors <= sat_inc(protocol_errors, push &&
                               ((gnt_code == 8'h03) || (gnt_code == 8'h04) || (gnt_code == 8'h06)));
            overflow_errors <= sat_inc(overflow_errors, push && full && !pop);
        end
    end

    // irq arms on any edge that writes an entry and leaves occupancy at or above the
    // threshold; that set beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else if (wr_en && (count_nxt >= THRESH_C))
            irq <= 1'b1;
        else if (irq_clear)
            irq <= 1'b0;
    end

endmodule
